// File: rtl/line_edit_ctrl_if.sv
// Committed-line character stream out of line_edit_ctrl.
// The master drives data/valid/last and the slave returns ready.
interface line_edit_ctrl_if;
    logic [7:0] o_out_char;
    logic       o_out_valid;
    logic       o_out_last;
    logic       i_out_ready;

    modport master (
        output o_out_char,
        output o_out_valid,
        output o_out_last,
        input  i_out_ready
    );

    modport slave (
        input  o_out_char,
        input  o_out_valid,
        input  o_out_last,
        output i_out_ready
    );
endinterface

// File: rtl/line_edit_ctrl.sv
// Line-edit controller: cursor-addressed character buffer with shifting
// insert/delete and a valid/ready commit stream.
// Optional: define LINE_EDIT_CURSOR_WRAP_EN to make left/right wrap.
module line_edit_ctrl #(
    parameter int DEPTH = 16,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          i_sclr,
    input  logic [7:0]    i_ascii,
    input  logic          i_ascii_en,
    input  logic          i_right_en,
    input  logic          i_left_en,
    input  logic          i_down_en,
    input  logic          i_backspace_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data,
    output logic [AW-1:0] o_cursor,
    output logic [AW-1:0] o_len,
    output logic          o_busy,
    output logic          o_drop,
    line_edit_ctrl_if.master out_if
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] DEP = AW'(DEPTH);
    localparam logic [AW-1:0] ONE = AW'(1);

    typedef enum logic [1:0] {IDLE, SHIFT_R, SHIFT_L, STREAM} state_t;

    state_t        state;
    state_t        state_nx;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] cursor;
    logic [AW-1:0] len;
    logic [AW-1:0] idx;
    logic [AW-1:0] ptr;
    logic [7:0]    ch;
    logic          drop;

    logic [AW-1:0] idx_m1;
    logic [AW-1:0] idx_p1;
    logic [AW-1:0] len_m1;
    logic          any_req;
    logic          take_down;
    logic          take_bs;
    logic          take_ascii;
    logic          take_left;
    logic          take_right;
    logic          last;

    assign idx_m1 = idx - ONE;
    assign idx_p1 = idx + ONE;
    assign len_m1 = len - ONE;
    assign last   = (ptr == len_m1);

    assign any_req = i_ascii_en | i_right_en | i_left_en
                   | i_down_en | i_backspace_en;

    // Fixed priority: down > backspace > ascii > left > right.
    assign take_down  = i_down_en;
    assign take_bs    = ~i_down_en & i_backspace_en;
    assign take_ascii = ~i_down_en & ~i_backspace_en & i_ascii_en;
    assign take_left  = ~i_down_en & ~i_backspace_en & ~i_ascii_en
                      & i_left_en;
    assign take_right = ~i_down_en & ~i_backspace_en & ~i_ascii_en
                      & ~i_left_en & i_right_en;

    assign o_rd_data = (i_rd_addr < DEP) ? mem[i_rd_addr[IW-1:0]] : 8'h00;
    assign o_cursor  = cursor;
    assign o_len     = len;
    assign o_busy    = (state != IDLE);
    assign o_drop    = drop;

    assign out_if.o_out_valid = (state == STREAM);
    assign out_if.o_out_char  = mem[ptr[IW-1:0]];
    assign out_if.o_out_last  = (state == STREAM) & last;

    // State register.
    always_ff @(posedge clk) begin
        if (i_sclr) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (take_down && len != '0)        state_nx = STREAM;
                else if (take_bs && cursor != '0)  state_nx = SHIFT_L;
                else if (take_ascii && len != DEP) state_nx = SHIFT_R;
            end
            SHIFT_R: if (idx == cursor) state_nx = IDLE;
            SHIFT_L: if (idx == len_m1) state_nx = IDLE;
            STREAM:  if (out_if.i_out_ready && last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Buffer, cursor/length and shift/stream pointers.
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
            cursor <= '0;
            len    <= '0;
            idx    <= '0;
            ptr    <= '0;
            ch     <= 8'h00;
            drop   <= 1'b0;
        end else begin
            drop <= (state != IDLE) ? any_req : (take_ascii && len == DEP);
            unique case (state)
                IDLE: begin
                    if (take_down) begin
                        ptr <= '0;
                    end else if (take_bs) begin
                        idx <= cursor - ONE;
                    end else if (take_ascii) begin
                        ch  <= i_ascii;
                        idx <= len;
                    end else if (take_left) begin
                        if (cursor != '0) cursor <= cursor - ONE;
`ifdef LINE_EDIT_CURSOR_WRAP_EN
                        else              cursor <= len;
`endif
                    end else if (take_right) begin
                        if (cursor != len) cursor <= cursor + ONE;
`ifdef LINE_EDIT_CURSOR_WRAP_EN
                        else               cursor <= '0;
`endif
                    end
                end
                SHIFT_R: begin
                    if (idx != cursor) begin
                        mem[idx[IW-1:0]] <= mem[idx_m1[IW-1:0]];
                        idx <= idx_m1;
                    end else begin
                        mem[cursor[IW-1:0]] <= ch;
                        cursor <= cursor + ONE;
                        len    <= len + ONE;
                    end
                end
                SHIFT_L: begin
                    if (idx != len_m1) begin
                        mem[idx[IW-1:0]] <= mem[idx_p1[IW-1:0]];
                        idx <= idx_p1;
                    end else begin
                        mem[len_m1[IW-1:0]] <= 8'h00;
                        cursor <= cursor - ONE;
                        len    <= len_m1;
                    end
                end
                STREAM: begin
                    if (out_if.i_out_ready) begin
                        if (last) begin
                            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
                            cursor <= '0;
                            len    <= '0;
                            ptr    <= '0;
                        end else begin
                            ptr <= ptr + ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_line_edit_ctrl.sv
// Bench for line_edit_ctrl: queue-based line model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_line_edit_ctrl;
    localparam int DEPTH = 16;
    localparam int AW    = 5;
`ifdef LINE_EDIT_CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          i_sclr = 1'b1;
    logic [7:0]    i_ascii = 8'h00;
    logic          i_ascii_en = 1'b0;
    logic          i_right_en = 1'b0;
    logic          i_left_en = 1'b0;
    logic          i_down_en = 1'b0;
    logic          i_backspace_en = 1'b0;
    logic [AW-1:0] i_rd_addr = '0;
    logic [7:0]    o_rd_data;
    logic [AW-1:0] o_cursor;
    logic [AW-1:0] o_len;
    logic          o_busy;
    logic          o_drop;

    line_edit_ctrl_if sif();

    line_edit_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk            (clk),
        .i_sclr         (i_sclr),
        .i_ascii        (i_ascii),
        .i_ascii_en     (i_ascii_en),
        .i_right_en     (i_right_en),
        .i_left_en      (i_left_en),
        .i_down_en      (i_down_en),
        .i_backspace_en (i_backspace_en),
        .i_rd_addr      (i_rd_addr),
        .o_rd_data      (o_rd_data),
        .o_cursor       (o_cursor),
        .o_len          (o_len),
        .o_busy         (o_busy),
        .o_drop         (o_drop),
        .out_if         (sif)
    );

    always #5 clk = ~clk;

    // Model: the line as a queue; 0 idle, 1 insert, 2 delete, 3 stream.
    byte unsigned line[$];
    int   mcur = 0;
    int   mst = 0;
    int   mcnt = 0;
    int   msptr = 0;
    logic [7:0] mch = 8'h00;
    bit   mdrop = 1'b0;

    int n_tests = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic model_step();
        bit anyr;
        int sz;
        anyr = i_ascii_en | i_right_en | i_left_en | i_down_en
             | i_backspace_en;
        sz = line.size();
        if (i_sclr) begin
            line.delete();
            mcur = 0; mst = 0; mcnt = 0; msptr = 0; mdrop = 1'b0;
            return;
        end
        mdrop = 1'b0;
        case (mst)
            0: begin
                if (i_down_en) begin
                    if (sz > 0) begin mst = 3; msptr = 0; end
                end else if (i_backspace_en) begin
                    if (mcur > 0) begin mst = 2; mcnt = sz - mcur + 1; end
                end else if (i_ascii_en) begin
                    if (sz == DEPTH) mdrop = 1'b1;
                    else begin
                        mst = 1; mch = i_ascii; mcnt = sz - mcur + 1;
                    end
                end else if (i_left_en) begin
                    if (mcur > 0) mcur--;
                    else if (WRAP) mcur = sz;
                end else if (i_right_en) begin
                    if (mcur < sz) mcur++;
                    else if (WRAP) mcur = 0;
                end
            end
            1, 2: begin
                mdrop = anyr;
                mcnt--;
                if (mcnt == 0) begin
                    if (mst == 1) begin
                        line.insert(mcur, mch);
                        mcur++;
                    end else begin
                        line.delete(mcur - 1);
                        mcur--;
                    end
                    mst = 0;
                end
            end
            default: begin
                mdrop = anyr;
                if (sif.i_out_ready) begin
                    if (msptr == sz - 1) begin
                        line.delete();
                        mcur = 0; msptr = 0; mst = 0;
                    end else begin
                        msptr++;
                    end
                end
            end
        endcase
    endtask

    task automatic compare();
        int sz;
        int a;
        int exp_rd;
        sz = line.size();
        a = int'(i_rd_addr);
        chk("len", 32'(o_len), sz);
        chk("cursor", 32'(o_cursor), mcur);
        chk("busy", 32'(o_busy), 32'(mst != 0));
        chk("drop", 32'(o_drop), 32'(mdrop));
        chk("valid", 32'(sif.o_out_valid), 32'(mst == 3));
        if (mst == 3) begin
            chk("out_char", 32'(sif.o_out_char), 32'(line[msptr]));
            chk("out_last", 32'(sif.o_out_last), 32'(msptr == sz - 1));
        end
        if (mst == 0 || mst == 3) begin
            exp_rd = (a < sz) ? int'(line[a]) : 0;
            chk("rd_data", 32'(o_rd_data), exp_rd);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) compare();
    end

    task automatic tick();
        @(posedge clk);
        #2;
        i_ascii_en = 1'b0;
        i_right_en = 1'b0;
        i_left_en = 1'b0;
        i_down_en = 1'b0;
        i_backspace_en = 1'b0;
        i_rd_addr = (i_rd_addr == 5'd19) ? 5'd0 : i_rd_addr + 5'd1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (o_busy && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'(o_busy), 0);
    endtask

    task automatic ins(input logic [7:0] c);
        int n;
        i_ascii = c;
        i_ascii_en = 1'b1;
        tick();
        wait_idle(n);
    endtask

    task automatic do_reset();
        i_sclr = 1'b1;
        tick();
        i_sclr = 1'b0;
    endtask

    task automatic peek(input logic [AW-1:0] a, input logic [7:0] exp,
                        input string nm);
        i_rd_addr = a;
        #1;
        chk(nm, 32'(o_rd_data), 32'(exp));
    endtask

    initial begin
        int n;
        sif.i_out_ready = 1'b0;
        tick();
        tick();
        i_sclr = 1'b0;
        chk_en = 1'b1;
        chk("rst_len", 32'(o_len), 0);
        chk("rst_cursor", 32'(o_cursor), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_valid", 32'(sif.o_out_valid), 0);

        ins(8'h41);
        ins(8'h42);
        i_left_en = 1'b1;
        tick();
        i_ascii = 8'h43;
        i_ascii_en = 1'b1;
        tick();
        wait_idle(n);
        chk("C_busy_cycles", n, 2);
        chk("ACB_len", 32'(o_len), 3);
        chk("ACB_cursor", 32'(o_cursor), 2);
        peek(5'd0, 8'h41, "ACB_0");
        peek(5'd1, 8'h43, "ACB_1");
        peek(5'd2, 8'h42, "ACB_2");

        i_backspace_en = 1'b1;
        tick();
        wait_idle(n);
        peek(5'd0, 8'h41, "AB_0");
        peek(5'd1, 8'h42, "AB_1");
        peek(5'd2, 8'h00, "AB_2");
        chk("AB_len", 32'(o_len), 2);
        chk("AB_cursor", 32'(o_cursor), 1);
        i_left_en = 1'b1;
        tick();
        i_backspace_en = 1'b1;
        tick();
        chk("bs0_drop", 32'(o_drop), 0);
        chk("bs0_busy", 32'(o_busy), 0);
        chk("bs0_cursor", 32'(o_cursor), 0);
        chk("bs0_len", 32'(o_len), 2);

        i_ascii = 8'h51;
        i_ascii_en = 1'b1;
        i_right_en = 1'b1;
        tick();
        wait_idle(n);
        chk("prio_cursor", 32'(o_cursor), 1);
        peek(5'd0, 8'h51, "prio_0");

        do_reset();
        for (int i = 0; i < DEPTH; i++) ins(8'(8'h61 + i));
        i_ascii = 8'h7a;
        i_ascii_en = 1'b1;
        tick();
        chk("full_drop", 32'(o_drop), 1);
        chk("full_busy", 32'(o_busy), 0);
        tick();
        chk("full_drop_pulse", 32'(o_drop), 0);
        chk("full_len", 32'(o_len), 16);
        peek(5'd15, 8'h70, "full_last");

        do_reset();
        ins(8'h48);
        ins(8'h49);
        i_down_en = 1'b1;
        tick();
        chk("st_valid0", 32'(sif.o_out_valid), 1);
        chk("st_char0", 32'(sif.o_out_char), 32'h48);
        chk("st_last0", 32'(sif.o_out_last), 0);
        tick();
        chk("st_hold0", 32'(sif.o_out_char), 32'h48);
        sif.i_out_ready = 1'b1;
        tick();
        sif.i_out_ready = 1'b0;
        chk("st_char1", 32'(sif.o_out_char), 32'h49);
        chk("st_last1", 32'(sif.o_out_last), 1);
        tick();
        chk("st_hold1", 32'(sif.o_out_char), 32'h49);
        sif.i_out_ready = 1'b1;
        tick();
        sif.i_out_ready = 1'b0;
        chk("st_done_valid", 32'(sif.o_out_valid), 0);
        chk("st_done_len", 32'(o_len), 0);
        chk("st_done_cursor", 32'(o_cursor), 0);
        peek(5'd0, 8'h00, "st_done_rd0");

        do_reset();
        for (int i = 0; i < 5; i++) ins(8'(8'h30 + i));
        for (int i = 0; i < 5; i++) begin
            i_left_en = 1'b1;
            tick();
        end
        i_ascii = 8'h5a;
        i_ascii_en = 1'b1;
        tick();
        i_right_en = 1'b1;
        tick();
        chk("busy_drop", 32'(o_drop), 1);
        wait_idle(n);
        chk("busy_cursor", 32'(o_cursor), 1);
        chk("busy_len", 32'(o_len), 6);
        peek(5'd0, 8'h5a, "busy_rd0");
        i_ascii = 8'h59;
        i_ascii_en = 1'b1;
        tick();
        tick();
        i_sclr = 1'b1;
        tick();
        i_sclr = 1'b0;
        chk("sclr_len", 32'(o_len), 0);
        chk("sclr_cursor", 32'(o_cursor), 0);
        chk("sclr_busy", 32'(o_busy), 0);
        peek(5'd0, 8'h00, "sclr_rd0");
        peek(5'd1, 8'h00, "sclr_rd1");

        do_reset();
        for (int i = 0; i < 3; i++) ins(8'(8'h61 + i));
        i_right_en = 1'b1;
        tick();
`ifdef LINE_EDIT_CURSOR_WRAP_EN
        chk("wrap_right", 32'(o_cursor), 0);
`else
        chk("wrap_right", 32'(o_cursor), 3);
`endif
        for (int k = 0; k < 8 && o_cursor != '0; k++) begin
            i_left_en = 1'b1;
            tick();
        end
        i_left_en = 1'b1;
        tick();
`ifdef LINE_EDIT_CURSOR_WRAP_EN
        chk("wrap_left", 32'(o_cursor), 3);
`else
        chk("wrap_left", 32'(o_cursor), 0);
`endif
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/line_edit_ctrl.md
Name: line_edit_ctrl

Overview:
Line-edit controller between the key decoder and the display/output path. It owns a DEPTH-entry character buffer with a cursor. Printable characters are inserted at the cursor, backspace deletes before the cursor, and left/right move the cursor. Down commits the line as a valid/ready character stream, then clears the buffer. Insert and delete shift the buffer one entry per cycle, so the block is busy for several cycles.

Parameters:
DEPTH, 16, buffer capacity in characters (>=2)
AW, 5, width of cursor/length/index fields; must satisfy 2**AW > DEPTH

Ports:
clk  input  1  clock
i_sclr  input  1  synchronous active-high reset
i_ascii  input  8  character for insert
i_ascii_en  input  1  one-cycle insert request
i_right_en  input  1  one-cycle cursor-right request
i_left_en  input  1  one-cycle cursor-left request
i_down_en  input  1  one-cycle commit request
i_backspace_en  input  1  one-cycle delete request
i_rd_addr  input  AW  display read address
o_rd_data  output  8  buf[i_rd_addr], combinational; 8'h00 if i_rd_addr>=DEPTH
o_cursor  output  AW  cursor position, 0..len
o_len  output  AW  characters stored, 0..DEPTH
o_busy  output  1  high in any state other than IDLE
o_drop  output  1  one-cycle pulse when a request is discarded
o_out_char  output  8  committed stream data
o_out_valid  output  1  stream valid
o_out_last  output  1  final character of the stream
i_out_ready  input  1  stream ready

Behaviour:
- Reset (i_sclr=1 at a clock edge, any state):
  - state=IDLE; buf, o_cursor, o_len all zero; o_out_valid, o_out_last, o_drop = 0.
  - Aborts a shift or stream in progress; o_out_valid is low the cycle after reset.
- States: IDLE, SHIFT_R, SHIFT_L, STREAM.
- Requests are accepted only in IDLE. Priority when several requests are high in one cycle: down > backspace > ascii > left > right. Lower-priority requests in that cycle are ignored silently (no o_drop).
- Any request high while o_busy=1 is discarded with o_drop=1 the next cycle. This includes the final cycle of SHIFT_R/SHIFT_L.
- ascii in IDLE:
  - If len==DEPTH: discard, o_drop=1, no change.
  - Else latch the character, idx<=len, go to SHIFT_R.
- SHIFT_R, one step per cycle:
  - If idx>cursor: buf[idx]<=buf[idx-1], idx--.
  - If idx==cursor: buf[cursor]<=char, cursor++, len++, go to IDLE.
  - Occupancy is len-cursor+1 cycles (1 cycle when cursor==len).
- backspace in IDLE:
  - If cursor==0: ignored, no o_drop.
  - Else idx<=cursor-1, go to SHIFT_L.
- SHIFT_L, one step per cycle:
  - If idx<len-1: buf[idx]<=buf[idx+1], idx++.
  - If idx==len-1: buf[len-1]<=8'h00, len--, cursor--, go to IDLE.
  - Occupancy is len-cursor+1 cycles.
- left/right in IDLE, single cycle, no busy:
  - left: cursor-- if cursor>0.
  - right: cursor++ if cursor<len.
  - At a limit the request is ignored (see optional feature).
- down in IDLE:
  - If len==0: ignored.
  - Else ptr<=0, go to STREAM.
- STREAM:
  - o_out_valid=1, o_out_char=buf[ptr], o_out_last=(ptr==len-1).
  - Outputs are held stable while i_out_ready=0.
  - On valid&&ready: ptr++.
  - On valid&&ready&&last: next cycle buf, len, cursor cleared; o_out_valid=0; state=IDLE.
- o_len and o_cursor update only on the cycle a shift completes; intermediate shift steps are not visible on them.
- o_rd_data reflects buf contents including intermediate shift steps.

Optional Feature:
LINE_EDIT_CURSOR_WRAP_EN
- Defined: left at cursor==0 sets cursor=len; right at cursor==len sets cursor=0. When len==0 the cursor stays 0.
- Undefined: left/right at a limit are ignored, as above.

Test Plan:
- Reset, insert 'A'(8'h41), 'B', left, insert 'C' -> buf="ACB", len=3, cursor=2. The 'C' insert holds o_busy for 2 cycles.
- From "ACB", cursor=2: backspace -> buf="AB", buf[2]=8'h00, len=2, cursor=1. Then left, backspace at cursor 0 -> no change, no o_drop.
- Insert DEPTH(16) characters, then a 17th -> o_drop pulses 1 cycle; len stays 16 and the buffer is unchanged.
- "HI", down, i_out_ready toggling 0,1,0,1 -> stream 8'h48 then 8'h49. o_out_last is high only with 8'h49, and data is held while ready=0. Afterwards len=0, cursor=0, o_rd_data(0)=8'h00.
- Insert at cursor 0 with len=5, and a right request pulsed during busy -> o_drop=1 and cursor=1 after completion. Assert i_sclr during a SHIFT_R -> all zero and IDLE next cycle.
- With LINE_EDIT_CURSOR_WRAP_EN, len=3: left at cursor 0 -> cursor=3; right at cursor 3 -> cursor=0. Without the macro, both requests leave the cursor unchanged.
